// File: rtl/two_cars_pkg.sv
// Shared keycodes, lane FSM state type and datapath widths for the two-car lane controller.
package two_cars_pkg;

    localparam int unsigned XW = 10;
    localparam int unsigned KW = 8;

    localparam logic [KW-1:0] KEY_NONE = 8'h00;
    localparam logic [KW-1:0] KEY_W    = 8'h1A;
    localparam logic [KW-1:0] KEY_S    = 8'h16;
    localparam logic [KW-1:0] KEY_A    = 8'h04;
    localparam logic [KW-1:0] KEY_D    = 8'h07;
    localparam logic [KW-1:0] KEY_8    = 8'h60;
    localparam logic [KW-1:0] KEY_5    = 8'h5D;
    localparam logic [KW-1:0] KEY_4    = 8'h5C;
    localparam logic [KW-1:0] KEY_6    = 8'h5E;

    typedef enum logic [1:0] {
        IDLE_L  = 2'd0,
        IDLE_R  = 2'd1,
        SLIDE_R = 2'd2,
        SLIDE_L = 2'd3
    } lane_state_t;

endpackage

// File: rtl/lane_fsm.sv
// One player's slide engine: key edge detect, lane FSM, saturating offset, registered x/lane/busy.
// TWO_CARS_BOOST_EN: holding UP_KEY during a slide doubles the per-tick step.
module lane_fsm
    import two_cars_pkg::*;
#(
    parameter logic [XW-1:0] X0        = 10'd80,
    parameter logic [XW-1:0] LANE_GAP  = 10'd80,
    parameter logic [XW-1:0] STEP      = 10'd8,
    parameter logic [KW-1:0] LEFT_KEY  = KEY_A,
    parameter logic [KW-1:0] RIGHT_KEY = KEY_D,
    parameter logic [KW-1:0] UP_KEY    = KEY_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          adv,
    input  logic [KW-1:0] key,
    output logic [XW-1:0] x,
    output logic          lane,
    output logic          busy
);

`ifdef TWO_CARS_BOOST_EN
    localparam logic BOOST = 1'b1;
`else
    localparam logic BOOST = 1'b0;
`endif

    lane_state_t   state, state_n;
    logic [XW-1:0] offset, offset_n;
    logic [KW-1:0] prev_key;
    logic          press_l, press_r, sliding;
    logic [XW:0]   step, sum, gap_w, off_w;
    logic [XW-1:0] off_up, off_dn;

    // Next state and saturating offset for an advancing tick.
    always_comb begin
        press_l  = (key == LEFT_KEY)  && (key != prev_key);
        press_r  = (key == RIGHT_KEY) && (key != prev_key);
        sliding  = (state == SLIDE_R) || (state == SLIDE_L);
        step     = (BOOST && sliding && (key == UP_KEY)) ? (11'(STEP) << 1) : 11'(STEP);
        gap_w    = 11'(LANE_GAP);
        off_w    = 11'(offset);
        sum      = off_w + step;
        off_up   = (sum >= gap_w) ? LANE_GAP : sum[XW-1:0];
        off_dn   = (off_w > step) ? 10'(off_w - step) : '0;
        state_n  = state;
        offset_n = offset;
        case (state)
            IDLE_L: if (press_r) begin
                state_n  = SLIDE_R;
                offset_n = off_up;
            end
            IDLE_R: if (press_l) begin
                state_n  = SLIDE_L;
                offset_n = off_dn;
            end
            SLIDE_R: if (press_l) begin
                offset_n = off_dn;
                state_n  = (off_dn == '0) ? IDLE_L : SLIDE_L;
            end else begin
                offset_n = off_up;
                state_n  = (off_up == LANE_GAP) ? IDLE_R : SLIDE_R;
            end
            SLIDE_L: if (press_r) begin
                offset_n = off_up;
                state_n  = (off_up == LANE_GAP) ? IDLE_R : SLIDE_R;
            end else begin
                offset_n = off_dn;
                state_n  = (off_dn == '0) ? IDLE_L : SLIDE_L;
            end
            default: begin
                state_n  = IDLE_L;
                offset_n = '0;
            end
        endcase
    end

    // State, key history and registered outputs; everything holds between advancing ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE_L;
            offset   <= '0;
            prev_key <= KEY_NONE;
            x        <= X0;
            lane     <= 1'b0;
            busy     <= 1'b0;
        end else if (adv) begin
            state    <= state_n;
            offset   <= offset_n;
            prev_key <= key;
            x        <= X0 + offset_n;
            lane     <= (state_n == IDLE_R) || (state_n == SLIDE_R);
            busy     <= (state_n == SLIDE_R) || (state_n == SLIDE_L);
        end
    end

endmodule

// File: rtl/player_lane_ctrl.sv
// Two-player lane controller: frame tick edge detect feeding one lane_fsm per player.
// TWO_CARS_BOOST_EN enables the hold-up-to-boost slide speed in both engines.
module player_lane_ctrl
    import two_cars_pkg::*;
#(
    parameter logic [XW-1:0] P1_X0    = 10'd80,
    parameter logic [XW-1:0] P2_X0    = 10'd400,
    parameter logic [XW-1:0] LANE_GAP = 10'd80,
    parameter logic [XW-1:0] STEP     = 10'd8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          frame_clk,
    input  logic          enable,
    input  logic [KW-1:0] player1_key,
    input  logic [KW-1:0] player2_key,
    output logic [XW-1:0] p1_x,
    output logic [XW-1:0] p2_x,
    output logic          p1_lane,
    output logic          p2_lane,
    output logic          p1_busy,
    output logic          p2_busy
);

    logic frame_q;
    logic adv;

    // Delayed frame strobe for rising-edge detection.
    always_ff @(posedge Clk) begin
        if (Reset) frame_q <= 1'b0;
        else       frame_q <= frame_clk;
    end

    assign adv = frame_clk & ~frame_q & enable;

    lane_fsm #(
        .X0(P1_X0), .LANE_GAP(LANE_GAP), .STEP(STEP),
        .LEFT_KEY(KEY_A), .RIGHT_KEY(KEY_D), .UP_KEY(KEY_W)
    ) u_p1 (
        .clk(Clk), .reset(Reset), .adv(adv), .key(player1_key),
        .x(p1_x), .lane(p1_lane), .busy(p1_busy)
    );

    lane_fsm #(
        .X0(P2_X0), .LANE_GAP(LANE_GAP), .STEP(STEP),
        .LEFT_KEY(KEY_4), .RIGHT_KEY(KEY_6), .UP_KEY(KEY_8)
    ) u_p2 (
        .clk(Clk), .reset(Reset), .adv(adv), .key(player2_key),
        .x(p2_x), .lane(p2_lane), .busy(p2_busy)
    );

endmodule

// File: tb/tb_player_lane_ctrl.sv
// Directed self-checking bench for player_lane_ctrl.
module tb_player_lane_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       enable;
    logic [7:0] player1_key, player2_key;
    logic [9:0] p1_x, p2_x;
    logic       p1_lane, p2_lane, p1_busy, p2_busy;

    int ncmp = 0;
    int nfail = 0;

    player_lane_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enable(enable),
        .player1_key(player1_key), .player2_key(player2_key),
        .p1_x(p1_x), .p2_x(p2_x), .p1_lane(p1_lane), .p2_lane(p2_lane),
        .p1_busy(p1_busy), .p2_busy(p2_busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_p1(input string tag, input int x, input int ln, input int bz);
        chk({tag, " p1_x"}, int'(p1_x), x);
        chk({tag, " p1_lane"}, int'(p1_lane), ln);
        chk({tag, " p1_busy"}, int'(p1_busy), bz);
    endtask

    task automatic chk_p2(input string tag, input int x, input int ln, input int bz);
        chk({tag, " p2_x"}, int'(p2_x), x);
        chk({tag, " p2_lane"}, int'(p2_lane), ln);
        chk({tag, " p2_busy"}, int'(p2_busy), bz);
    endtask

    // One frame tick: strobe high for one Clk, low for one, then sample on a falling edge.
    task automatic tick();
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
        @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk) Reset = 1'b0;
        player1_key = 8'h00;
        player2_key = 8'h00;
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; enable = 1'b1;
        player1_key = 8'h00; player2_key = 8'h00;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;

        // 1: reset state, idle ticks, foreign / up keys ignored
        chk_p1("rst", 80, 0, 0);
        chk_p2("rst", 400, 0, 0);
        repeat (20) tick();
        chk_p1("idle20", 80, 0, 0);
        chk_p2("idle20", 400, 0, 0);
        player1_key = 8'h5E; player2_key = 8'h07; tick();
        chk_p1("foreign", 80, 0, 0);
        chk_p2("foreign", 400, 0, 0);
        player1_key = 8'h04; player2_key = 8'h5C; tick();
        chk_p1("left_in_L", 80, 0, 0);
        chk_p2("left_in_L", 400, 0, 0);

        // 2: held right = one full slide, then held
        do_reset();
        player1_key = 8'h07;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k < 10) chk_p1($sformatf("hold%0d", k), 80 + 8 * k, 1, 1);
            else        chk_p1($sformatf("hold%0d", k), 160, 1, 0);
        end
        chk_p2("hold p2", 400, 0, 0);

        // frame_clk held high counts as a single tick
        do_reset();
        player1_key = 8'h07;
        @(negedge Clk) frame_clk = 1'b1;
        repeat (5) @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);
        chk_p1("level", 88, 1, 1);

        // 3: release, then reverse mid-slide
        do_reset();
        player1_key = 8'h07; tick(); chk_p1("rev t0", 88, 1, 1);
        player1_key = 8'h00; tick(); chk_p1("rev t1", 96, 1, 1);
        tick();              chk_p1("rev t2", 104, 1, 1);
        player1_key = 8'h04; tick(); chk_p1("rev t3", 96, 0, 1);
        tick();              chk_p1("rev t4", 88, 0, 1);
        tick();              chk_p1("rev t5", 80, 0, 0);
        tick();              chk_p1("rev t6", 80, 0, 0);
        player1_key = 8'h00; tick();
        player1_key = 8'h04; tick(); chk_p1("rev leftL", 80, 0, 0);

        // 4: both players together, then p2 slides back left
        do_reset();
        player1_key = 8'h07; player2_key = 8'h5E;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("lock%0d p1_x", k), int'(p1_x), 80 + 8 * k);
            chk($sformatf("lock%0d p2_x", k), int'(p2_x), 400 + 8 * k);
        end
        chk_p1("lock end", 160, 1, 0);
        chk_p2("lock end", 480, 1, 0);
        player2_key = 8'h5C; tick(); chk_p2("p2 left1", 472, 0, 1);
        player2_key = 8'h5E; tick(); chk_p2("p2 back", 480, 1, 0);

        // 5: enable low loses ticks and freezes key history
        do_reset();
        player1_key = 8'h07;
        repeat (5) tick();
        chk_p1("en pre", 120, 1, 1);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            player1_key = (k % 2 == 0) ? 8'h04 : 8'h00;
            tick();
        end
        chk_p1("en frozen", 120, 1, 1);
        enable = 1'b1; player1_key = 8'h07; tick();
        chk_p1("en resume", 128, 1, 1);

        // 6: reset mid-slide, no slide resumes
        do_reset();
        player1_key = 8'h07;
        repeat (7) tick();
        chk_p1("mid pre", 136, 1, 1);
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk) Reset = 1'b0;
        chk_p1("mid rst", 80, 0, 0);
        player1_key = 8'h00;
        repeat (3) tick();
        chk_p1("mid after", 80, 0, 0);

`ifdef TWO_CARS_BOOST_EN
        do_reset();
        player1_key = 8'h07; tick(); chk_p1("boost t1", 88, 1, 1);
        player1_key = 8'h1A;
        tick(); chk_p1("boost t2", 104, 1, 1);
        tick(); chk_p1("boost t3", 120, 1, 1);
        tick(); chk_p1("boost t4", 136, 1, 1);
        tick(); chk_p1("boost t5", 152, 1, 1);
        tick(); chk_p1("boost t6", 160, 1, 0);
`else
        do_reset();
        player1_key = 8'h07; tick();
        player1_key = 8'h1A; tick(); chk_p1("noboost", 96, 1, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
